// File: rtl/l2resp_buf_pkg.sv
// Shared response-entry layout for the L2 return path; also used by the dcache miss handler.
package l2resp_buf_pkg;

  localparam int ENTRY_W = 63;

  // Field order {addr, wen, rdata} is fixed: the miss handler unpacks the same layout.
  typedef struct packed {
    logic [29:0] addr;
    logic        wen;
    logic [31:0] rdata;
  } resp_entry_t;

endpackage

// File: rtl/l2resp_buf_chk.sv
// Simulation-only invariant checks for the L2 response buffer.
module l2resp_buf_chk #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic        clk,
  input logic        rst,
  input logic        l2req_fire,
  input logic        issue_ok,
  input logic [AW:0] outstanding,
  input logic [AW:0] count
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  // Upstream must never fire without permission; counters must stay ordered.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(l2req_fire && !issue_ok))
        else $error("l2resp_buf: request fired while issue_ok=0");
      assert (outstanding <= DEPTH_CNT)
        else $error("l2resp_buf: outstanding exceeds DEPTH");
      assert (count <= outstanding)
        else $error("l2resp_buf: occupancy exceeds outstanding");
    end
  end

endmodule

// File: rtl/l2resp_buf_store.sv
// Response storage: array plus wrap-bit pointers, exposing full/empty/occupancy.
module l2resp_buf_store
  import l2resp_buf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        count
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [AW:0]        wr_ptr_r;
  logic [AW:0]        rd_ptr_r;

  // Pointer registers; the top bit toggles on each wrap to tell full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_en) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_en) rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Entry array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count   = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/l2resp_buf.sv
// L2 -> dcache response buffer with outstanding-request accounting and a sticky protocol error.
module l2resp_buf
  import l2resp_buf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        l2req_fire,
  output logic        l2resp_issue_ok,
  input  logic        l2_l2resp_valid,
  input  logic [29:0] l2_l2resp_addr,
  input  logic        l2_l2resp_wen,
  input  logic [31:0] l2_l2resp_rdata,
  output logic        l2resp_l2_ready,
  output logic        l2resp_dc_valid,
  output logic [29:0] l2resp_dc_addr,
  output logic        l2resp_dc_wen,
  output logic [31:0] l2resp_dc_rdata,
  input  logic        dcache_l2resp_ready,
  output logic        l2resp_err,
  output logic [AW:0] l2resp_count
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0] CNT_ZERO  = (AW+1)'(0);

  logic [AW:0] outstanding_r;
  logic [AW:0] outstanding_nxt_s;
  logic [AW:0] count_s;
  logic [AW:0] pending_s;
  logic        full_s;
  logic        empty_s;
  logic        resp_accept_s;
  logic        resp_drop_s;
  logic        dc_pop_s;
  logic        err_r;
  resp_entry_t wr_entry_s;
  resp_entry_t rd_entry_s;
  resp_entry_t head_s;

  assign wr_entry_s = '{addr: l2_l2resp_addr, wen: l2_l2resp_wen, rdata: l2_l2resp_rdata};

  l2resp_buf_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (resp_accept_s),
    .wr_data (wr_entry_s),
    .rd_en   (dc_pop_s),
    .rd_data (rd_entry_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (count_s)
  );

  // Pending uses registered state only, so a same-cycle request never legalises a response.
  assign pending_s       = outstanding_r - count_s;
  assign l2resp_l2_ready = !full_s;
  assign resp_accept_s   = l2_l2resp_valid & !full_s & (pending_s != CNT_ZERO);
  assign resp_drop_s     = l2_l2resp_valid & !full_s & (pending_s == CNT_ZERO);
  assign dc_pop_s        = !empty_s & dcache_l2resp_ready;
  assign l2resp_issue_ok = (outstanding_r < DEPTH_CNT);
  assign l2resp_count    = count_s;
  assign l2resp_err      = err_r;

  // Outstanding next value; saturates at DEPTH if upstream ignores issue_ok.
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    if (l2req_fire && !dc_pop_s) begin
      if (outstanding_r != DEPTH_CNT) outstanding_nxt_s = outstanding_r + CNT_ONE;
      else                            outstanding_nxt_s = outstanding_r;
    end else if (!l2req_fire && dc_pop_s) begin
      outstanding_nxt_s = outstanding_r - CNT_ONE;
    end else begin
      outstanding_nxt_s = outstanding_r;
    end
  end

  // Outstanding counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_r <= CNT_ZERO;
      err_r         <= 1'b0;
    end else begin
      outstanding_r <= outstanding_nxt_s;
      if (resp_drop_s) err_r <= 1'b1;
    end
  end

  // Head fields read as zero while empty so unreset storage never leaks out.
  always_comb begin
    head_s = '{addr: 30'd0, wen: 1'b0, rdata: 32'd0};
    if (empty_s) head_s = '{addr: 30'd0, wen: 1'b0, rdata: 32'd0};
    else         head_s = rd_entry_s;
  end

  assign l2resp_dc_valid = !empty_s;
  assign l2resp_dc_addr  = head_s.addr;
  assign l2resp_dc_wen   = head_s.wen;
  assign l2resp_dc_rdata = head_s.rdata;

  l2resp_buf_chk #(.DEPTH(DEPTH), .AW(AW)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .l2req_fire  (l2req_fire),
    .issue_ok    (l2resp_issue_ok),
    .outstanding (outstanding_r),
    .count       (count_s)
  );

endmodule

// File: doc/l2resp_buf.md
Name: l2resp_buf

Overview:
- Return path from L2 to the dcache: the opposite direction of the dcache→L2 request FIFO.
- Buffers L2 responses (read data or write acks, one per request, in order) and presents them to the dcache over a valid/ready handshake.
- Tracks outstanding requests and withholds issue permission from the request side, so every response is guaranteed a buffer slot.
- Flags protocol violations, i.e. a response arriving with no request pending.

Parameters:
DEPTH, 8, response entries; power of two, ≥2; also the maximum number of outstanding requests.
AW, 3, log2(DEPTH); pointer index width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
l2req_fire  in  1  request accepted by L2 this cycle (request valid & L2 ready on the request path).
l2resp_issue_ok  out  1  request side may issue; 1 when outstanding < DEPTH.
l2_l2resp_valid  in  1  L2 response valid.
l2_l2resp_addr  in  30  [31:2] word address of the response.
l2_l2resp_wen  in  1  1 = write ack, 0 = read data.
l2_l2resp_rdata  in  32  read data; don't-care when wen=1.
l2resp_l2_ready  out  1  buffer can accept a response.
l2resp_dc_valid  out  1  response available to dcache.
l2resp_dc_addr  out  30  head entry address.
l2resp_dc_wen  out  1  head entry wen.
l2resp_dc_rdata  out  32  head entry data.
dcache_l2resp_ready  in  1  dcache consumes the head entry.
l2resp_err  out  1  sticky: a response arrived with nothing pending.
l2resp_count  out  AW+1  current number of occupied entries (debug/perf).

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers, outstanding counter and err cleared.
  - Outputs: dc_valid=0, l2_ready=1, issue_ok=1, err=0, count=0; dc_addr/wen/rdata=0.
  - Entry storage is not reset.
- Storage:
  - DEPTH×63-bit array, {addr,wen,rdata}.
  - wr_ptr/rd_ptr are AW+1 bits with a wrap bit.
  - full = same index and differing wrap bit; empty = pointers equal.
  - count = wr_ptr − rd_ptr (mod 2^(AW+1)).
- Outstanding counter:
  - AW+1 bits, counts requests issued but not yet consumed by the dcache.
  - Next value = outstanding + l2req_fire − dc_pop.
  - A simultaneous fire and pop leave it unchanged.
  - pending = outstanding − count: requests awaiting an L2 response.
  - issue_ok = (outstanding < DEPTH), combinational from registered state.
- Accept:
  - l2_ready = !full.
  - resp_accept = l2_valid & l2_ready & (pending ≠ 0).
  - On accept, write the entry at wr_ptr and increment wr_ptr.
  - pending uses registered values; a request firing in the same cycle does not make that cycle's response legal.
- Error:
  - A response with l2_valid & l2_ready & pending==0 is dropped and sets l2resp_err.
  - err stays set until reset.
- Output:
  - dc_valid = !empty; dc_* fields are the entry at rd_ptr.
  - Read of the array is combinational; no registered output stage.
  - Write-to-visible latency is 1 cycle: a response accepted in cycle N presents at the dcache in N+1. There is no same-cycle bypass.
- Pop:
  - dc_pop = dc_valid & dcache_l2resp_ready; increments rd_ptr and decrements outstanding.
  - Simultaneous accept and pop when full: l2_ready=0 that cycle, so no accept occurs; the pop still proceeds.
  - Simultaneous accept and pop when non-full and non-empty: count is unchanged.
- Invariants:
  - outstanding ≤ DEPTH and count ≤ outstanding.
  - If the request side honours issue_ok, full never coincides with pending>0.
  - l2req_fire while issue_ok=0 is a protocol error upstream and must be caught by an assertion in simulation. The counter saturates at DEPTH.
- Reset mid-operation: all in-flight state is discarded; the dcache must also reset, since no responses are replayed.
- Pointer wrap: the index wraps modulo DEPTH and the wrap bit toggles. Ordering is preserved across the wrap.

Decomposition:
- Shared package: response entry width constant (63) and the field-packing order {addr,wen,rdata}. These are shared with the dcache miss handler.
- One natural sub-module: the existing generic fifo is unsuitable (it has no occupancy output), so build l2resp_store: array plus pointers, exposing full/empty/count. It can later replace the generic fifo.
- Outstanding/pending/err logic lives in the top module.

Test Plan:
- Reset, then 3 read fires, then L2 returns addr 0x100/0x101/0x102 with data 0xA0/0xA1/0xA2 on consecutive cycles, dcache_ready=1 → dc_valid rises 1 cycle after each accept; data in order; outstanding returns to 0.
- 8 fires with no pops → issue_ok=0 after the 8th. 8 responses with dcache_ready=0 → count=8, l2_ready=0. Pop one → issue_ok=1 and l2_ready=1 next cycle.
- l2_valid with no prior fire → response dropped, err=1 and held; count stays 0.
- Steady stream of 20 fire/response/pop triples across the wrap with DEPTH=8 → all 20 delivered in order with no loss; err=0.
- Write ack (wen=1, addr 0x2000) interleaved between two reads → dc_wen sequence 0,1,0 with matching addresses.
- Assert rst low with 5 entries buffered → same cycle dc_valid=0, count=0, issue_ok=1; no stale entry appears after release.
